// File: rtl/instr_fetch.sv
// Instruction fetch stage for the single-issue RV32I core.
// Holds the PC, issues word reads to instruction memory (one outstanding at most)
// and presents one instruction at a time to the decoder. A redirect from the
// branch logic loads a new PC and discards any fetch it makes stale.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   imem_req_o/addr_o      word read request and its address
//   imem_ack_i/rdata_i     memory response
//   instr_o/instr_valid_o  instruction to decoder, valid while held
//   instr_ready_i          decoder consumes instr_o this cycle
//   pc_o                   address of instr_o (or of the fetch in progress)
//   redirect_i/redirect_pc_i  branch taken and its target
//   fetch_cnt_o            instructions handed to the decoder
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {StStart, StFetch, StHold, StDrain} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] instr_q;
    logic [31:0] cnt_q;
    logic        req_q;
    logic        valid_q;

    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = {redirect_pc_i[31:2], 2'b00};
    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StStart;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StStart: begin
                    state_q    <= StFetch;
                    req_addr_q <= pc_q;
                    req_q      <= 1'b1;
                end
                StFetch: begin
                    if (redirect_i) begin
                        pc_q <= target;
                        if (imem_ack_i) begin
                            // Stale data dropped; reissue straight to the target.
                            req_addr_q <= target;
                        end else begin
                            // Request still in flight: wait for its ack before reissuing.
                            state_q <= StDrain;
                        end
                    end else if (imem_ack_i) begin
                        instr_q <= imem_rdata_i;
                        state_q <= StHold;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (redirect_i) begin
                        pc_q <= target;
                    end
                    if (imem_ack_i) begin
                        // A redirect arriving with the ack is the newest target.
                        req_addr_q <= redirect_i ? target : pc_q;
                        state_q    <= StFetch;
                    end
                end
                StHold: begin
                    if (redirect_i) begin
                        pc_q       <= target;
                        req_addr_q <= target;
                        state_q    <= StFetch;
                        req_q      <= 1'b1;
                        valid_q    <= 1'b0;
                    end else if (instr_ready_i) begin
                        cnt_q      <= cnt_q + 32'd1;
                        pc_q       <= pc_inc;
                        req_addr_q <= pc_inc;
                        state_q    <= StFetch;
                        req_q      <= 1'b1;
                        valid_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StStart;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = req_addr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Memory data is addr + 32'h1000_0013 so every
// captured word identifies its fetch address. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .pc_o          (pc),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fetch_cnt_o   (fetch_cnt)
    );

    assign imem_rdata = imem_addr + 32'h1000_0013;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++;
            $display("FAIL reset_req got %0b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++;
            $display("FAIL reset_addr got %h want 00000000", imem_addr); end
        checks++; if (instr !== 32'h0000_0013) begin errors++;
            $display("FAIL reset_instr got %h want 00000013", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %0b want 0", instr_valid); end
        checks++; if (pc !== 32'h0) begin errors++;
            $display("FAIL reset_pc got %h want 00000000", pc); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++;
            $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
        rst_n = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
        step();  // START -> FETCH at the first rising edge
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || instr_valid !== 1'b0)
                begin errors++;
                $display("FAIL seq_req%0d got req=%0b addr=%h valid=%0b want 1 %h 0",
                         i, imem_req, imem_addr, instr_valid, 32'(4 * i)); end
            step();
            checks++; if (instr_valid !== 1'b1 || instr !== 32'(4 * i) + 32'h1000_0013 ||
                          pc !== 32'(4 * i)) begin errors++;
                $display("FAIL seq_hold%0d got valid=%0b instr=%h pc=%h", i, instr_valid,
                         instr, pc); end
            step();
        end
        checks++; if (fetch_cnt !== 32'd4) begin errors++;
            $display("FAIL seq_cnt got %0d want 4", fetch_cnt); end
        imem_ack = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0)
                begin errors++;
                $display("FAIL stall%0d got req=%0b addr=%h valid=%0b want 1 00000010 0",
                         i, imem_req, imem_addr, instr_valid); end
            step();
        end
        imem_ack = 1'b1;
        step();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0023 || pc !== 32'h10)
            begin errors++;
            $display("FAIL stall_data got valid=%0b instr=%h pc=%h want 1 10000023 00000010",
                     instr_valid, instr, pc); end
        imem_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0023 || pc !== 32'h10 ||
                          imem_req !== 1'b0 || fetch_cnt !== 32'd4) begin errors++;
                $display("FAIL bp%0d got valid=%0b instr=%h pc=%h req=%0b cnt=%0d", i,
                         instr_valid, instr, pc, imem_req, fetch_cnt); end
            step();
        end
        instr_ready = 1'b1;
        step();
        checks++; if (instr_valid !== 1'b0 || fetch_cnt !== 32'd5 || imem_addr !== 32'h14 ||
                      imem_req !== 1'b1) begin errors++;
            $display("FAIL bp_release got valid=%0b cnt=%0d addr=%h req=%0b want 0 5 14 1",
                     instr_valid, fetch_cnt, imem_addr, imem_req); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_fetch();
        // Redirect together with ack: reissue immediately to 8.
        redirect = 1'b1; redirect_pc = 32'h8; imem_ack = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h8 || pc !== 32'h8 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_ack got addr=%h pc=%h valid=%0b want 8 8 0", imem_addr, pc,
                     instr_valid); end
        // Redirect with the fetch at 8 still outstanding.
        redirect_pc = 32'h0000_0103; imem_ack = 1'b0;
        step();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h8 || pc !== 32'h100 || imem_req !== 1'b1 ||
                      instr_valid !== 1'b0) begin errors++;
            $display("FAIL redir_drain got addr=%h pc=%h req=%0b valid=%0b want 8 100 1 0",
                     imem_addr, pc, imem_req, instr_valid); end
        step();
        imem_ack = 1'b1;  // stale ack for address 8
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h100 || pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_stale got valid=%0b addr=%h pc=%h want 0 100 100",
                     instr_valid, imem_addr, pc); end
        step();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_wait got valid=%0b req=%0b addr=%h want 0 1 100",
                     instr_valid, imem_req, imem_addr); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0113 || pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_data got valid=%0b instr=%h pc=%h want 1 10000113 100",
                     instr_valid, instr, pc); end
    endtask

    task automatic test_redirect_hold();
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        instr_ready = 1'b0; redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || fetch_cnt !== 32'd5 || imem_addr !== 32'h200 ||
                      pc !== 32'h200 || imem_req !== 1'b1) begin errors++;
            $display("FAIL hold_redir got valid=%0b cnt=%0d addr=%h pc=%h req=%0b", instr_valid,
                     fetch_cnt, imem_addr, pc, imem_req); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_ack = 1'b1;
        step();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_target got addr=%h pc=%h want fffffffc", imem_addr, pc); end
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1000_000F) begin errors++;
            $display("FAIL wrap_data got valid=%0b instr=%h want 1 1000000f", instr_valid,
                     instr); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (imem_addr !== 32'h0 || pc !== 32'h0 || fetch_cnt !== 32'd6 ||
                      imem_req !== 1'b1) begin errors++;
            $display("FAIL wrap_next got addr=%h pc=%h cnt=%0d req=%0b want 0 0 6 1",
                     imem_addr, pc, fetch_cnt, imem_req); end
    endtask

    task automatic test_async_reset();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc !== 32'h40) begin errors++;
            $display("FAIL drain_setup got req=%0b addr=%h pc=%h want 1 0 40", imem_req,
                     imem_addr, pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0000_0013 ||
                      instr_valid !== 1'b0 || pc !== 32'h0 || fetch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got req=%0b addr=%h instr=%h valid=%0b pc=%h cnt=%0d",
                     imem_req, imem_addr, instr, instr_valid, pc, fetch_cnt); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_backpressure();
        test_redirect_fetch();
        test_redirect_hold();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-issue RV32I core. Holds the program counter, issues word reads to instruction memory over a req/ack handshake and presents one 32-bit instruction at a time to the decoder with a valid/ready handshake. Accepts a redirect from the branch logic and discards any fetch made stale by it. At most one memory request is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset (word-aligned)
- NOP_INSTR, 32'h0000_0013, instruction register value after reset (ADDI x0,x0,0)

- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  request word address, bits [1:0] always 0
- imem_ack  in  1  memory returns data this cycle; only meaningful while imem_req=1
- imem_rdata  in  32  read data, valid when imem_ack=1
- instr  out  32  instruction to decoder
- instr_valid  out  1  instr and pc are valid
- instr_ready  in  1  decoder consumes instr this cycle
- pc  out  32  address of instr (or of the fetch in progress)
- redirect  in  1  branch taken; load new PC
- redirect_pc  in  32  branch target; bits [1:0] ignored (forced 0)
- fetch_cnt  out  32  number of instructions handed to the decoder

## Operation
- States: START, FETCH, HOLD, DRAIN. Reset state START.
- Registers: pc_q (next/current instruction address), req_addr (address of outstanding request), instr_q, cnt_q.
- imem_req = 1 in FETCH and DRAIN only; imem_addr = req_addr. imem_addr must not change while imem_req=1 and imem_ack=0.
- START: unconditionally -> FETCH next edge, req_addr <= pc_q.
- FETCH, no redirect: on imem_ack, instr_q <= imem_rdata -> HOLD. Without ack, stay.
- FETCH, redirect with imem_ack: data discarded, pc_q <= target, req_addr <= target, stay FETCH.
- FETCH, redirect without imem_ack: pc_q <= target -> DRAIN (req_addr kept).
- DRAIN: on imem_ack discard data, req_addr <= pc_q -> FETCH. Further redirect in DRAIN only updates pc_q (last one wins).
- HOLD: instr_valid=1. On instr_ready (no redirect): cnt_q += 1, pc_q <= pc_q+4, req_addr <= pc_q+4 -> FETCH.
- HOLD, redirect (with or without instr_ready): redirect wins; held instruction dropped, cnt_q unchanged, pc_q/req_addr <= target -> FETCH.
- instr_valid = (state==HOLD). pc output = pc_q.
- Arithmetic: pc_q+4 modulo 2^32 (32'hFFFF_FFFC -> 0). cnt_q wraps modulo 2^32.
- imem_ack outside FETCH/DRAIN is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, instr_valid=0, pc=RESET_PC, fetch_cnt=0. Asserting rst_n low mid-operation returns all outputs to these values immediately; an outstanding memory request is abandoned.
- First imem_req high on the cycle after the first rising edge following rst_n release.
- Fetch latency: imem_ack sampled at edge N -> instr_valid high from edge N, same cycle instr=captured data.
- Best-case throughput (ack in first FETCH cycle, ready in first HOLD cycle): one instruction per 2 cycles.
- Redirect sampled at edge N: instr_valid low after edge N; first request to target issued after edge N (FETCH) or after the stale ack (DRAIN).
- instr, pc stable while instr_valid=1 and instr_ready=0.

## Test plan
- Reset/sequential: RESET_PC=0, memory acks in 1 cycle, ready always 1 -> imem_addr 0,4,8,12; instr_valid every 2nd cycle; fetch_cnt=4 after 4 handoffs.
- Memory stall: ack delayed 3 cycles -> imem_req high and imem_addr constant for all 3 cycles; instr_valid only after ack.
- Decoder backpressure: instr_ready low 5 cycles in HOLD -> instr/pc held, no new imem_req, fetch_cnt unchanged until ready.
- Redirect during outstanding fetch: redirect_pc=32'h0000_0103 while FETCH at addr 8, ack 2 cycles later -> data from 8 never valid; next imem_addr=32'h100; pc=32'h100.
- Redirect vs ready in HOLD same cycle -> held instruction dropped, fetch_cnt unchanged, next imem_addr=target.
- Wrap and async reset: pc=32'hFFFF_FFFC consumed -> next imem_addr=0; rst_n low mid-DRAIN -> all outputs reset values without a clock edge.
